// File: rtl/versatile_mem_ctrl_wb_rr.sv
// Round-robin Wishbone B3 front-end: one command per burst, beat-counted data phase,
// CTI/BTE burst decode, linear-burst continuation and flush of aborted bursts.
module versatile_mem_ctrl_wb_rr #(
  parameter int unsigned NR_OF_PORTS = 4,
  parameter int unsigned ADR_WIDTH   = 30,
  parameter int unsigned DAT_WIDTH   = 32
) (
  input  logic                                    wb_clk,
  input  logic                                    wb_rst,
  input  logic [NR_OF_PORTS*ADR_WIDTH-1:0]        wb_adr_i_v,
  input  logic [NR_OF_PORTS*DAT_WIDTH-1:0]        wb_dat_i_v,
  input  logic [NR_OF_PORTS*(DAT_WIDTH/8)-1:0]    wb_sel_i_v,
  input  logic [NR_OF_PORTS*3-1:0]                wb_cti_i_v,
  input  logic [NR_OF_PORTS*2-1:0]                wb_bte_i_v,
  input  logic [0:NR_OF_PORTS-1]                  wb_we_i,
  input  logic [0:NR_OF_PORTS-1]                  wb_cyc_i,
  input  logic [0:NR_OF_PORTS-1]                  wb_stb_i,
  output logic [DAT_WIDTH-1:0]                    wb_dat_o,
  output logic [0:NR_OF_PORTS-1]                  wb_ack_o,
  output logic                                    cmd_valid,
  input  logic                                    cmd_ready,
  output logic                                    cmd_we,
  output logic [ADR_WIDTH-1:0]                    cmd_adr,
  output logic [4:0]                              cmd_len,
  output logic                                    wr_valid,
  input  logic                                    wr_ready,
  output logic [DAT_WIDTH-1:0]                    wr_dat,
  output logic [DAT_WIDTH/8-1:0]                  wr_sel,
  input  logic                                    rd_valid,
  output logic                                    rd_ready,
  input  logic [DAT_WIDTH-1:0]                    rd_dat
);

  localparam int unsigned SEL_WIDTH = DAT_WIDTH / 8;
  localparam int unsigned PW        = (NR_OF_PORTS > 1) ? $clog2(NR_OF_PORTS) : 1;

  typedef enum logic [2:0] {StIdle, StCmd, StWr, StRd, StFlush} state_e;

  state_e               r_state;
  logic [PW-1:0]        r_grant;
  logic [PW-1:0]        r_ptr;
  logic                 r_we;
  logic [ADR_WIDTH-1:0] r_adr;
  logic [4:0]           r_len;
  logic [4:0]           r_cnt;

  logic                 w_any;
  logic [PW-1:0]        w_win;
  logic [PW-1:0]        w_idx;
  logic                 w_win_we;
  logic [ADR_WIDTH-1:0] w_win_adr;
  logic [2:0]           w_win_cti;
  logic [1:0]           w_win_bte;
  logic [DAT_WIDTH-1:0] w_dat_g;
  logic [SEL_WIDTH-1:0] w_sel_g;
  logic [2:0]           w_cti_g;
  logic [1:0]           w_bte_g;
  logic                 w_req_g;
  logic                 w_cyc_g;
  logic                 w_linear;
  logic                 w_beat_ack;
  logic                 w_flush_beat;
  logic [4:0]           w_cnt_dec;

  function automatic logic [4:0] f_len(input logic [2:0] cti, input logic [1:0] bte);
    logic [4:0] len;
    len = 5'd1;
    if (cti == 3'b010) begin
      case (bte)
        2'b01:   len = 5'd4;
        2'b10:   len = 5'd8;
        2'b11:   len = 5'd16;
        default: len = 5'd1;
      endcase
    end
    return len;
  endfunction

  // Scan downwards so the nearest requester after the pointer is the last (winning) write.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int unsigned i = NR_OF_PORTS; i >= 1; i--) begin
      w_idx = PW'((int'(r_ptr) + i) % NR_OF_PORTS);
      if (wb_cyc_i[w_idx] && wb_stb_i[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  always_comb begin
    w_dat_g   = '0;
    w_sel_g   = '0;
    w_cti_g   = '0;
    w_bte_g   = '0;
    w_win_adr = '0;
    w_win_cti = '0;
    w_win_bte = '0;
    for (int unsigned p = 0; p < NR_OF_PORTS; p++) begin
      if (r_grant == PW'(p)) begin
        w_dat_g = wb_dat_i_v[(NR_OF_PORTS-1-p)*DAT_WIDTH +: DAT_WIDTH];
        w_sel_g = wb_sel_i_v[(NR_OF_PORTS-1-p)*SEL_WIDTH +: SEL_WIDTH];
        w_cti_g = wb_cti_i_v[(NR_OF_PORTS-1-p)*3 +: 3];
        w_bte_g = wb_bte_i_v[(NR_OF_PORTS-1-p)*2 +: 2];
      end
      if (w_win == PW'(p)) begin
        w_win_adr = wb_adr_i_v[(NR_OF_PORTS-1-p)*ADR_WIDTH +: ADR_WIDTH];
        w_win_cti = wb_cti_i_v[(NR_OF_PORTS-1-p)*3 +: 3];
        w_win_bte = wb_bte_i_v[(NR_OF_PORTS-1-p)*2 +: 2];
      end
    end
  end

  assign w_win_we = wb_we_i[w_win];
  assign w_cyc_g  = wb_cyc_i[r_grant];
  assign w_req_g  = wb_cyc_i[r_grant] & wb_stb_i[r_grant];
  assign w_linear = (w_cti_g == 3'b010) && (w_bte_g == 2'b00);

  assign cmd_valid = (r_state == StCmd);
  assign cmd_we    = r_we;
  assign cmd_adr   = r_adr;
  assign cmd_len   = r_len;
  assign wr_valid  = ((r_state == StWr) & w_req_g) | ((r_state == StFlush) & r_we);
  assign wr_dat    = (r_state == StWr) ? w_dat_g : '0;
  assign wr_sel    = (r_state == StWr) ? w_sel_g : '0;
  assign rd_ready  = ((r_state == StRd) & w_req_g) | ((r_state == StFlush) & ~r_we);
  assign wb_dat_o  = (r_state == StRd) ? rd_dat : '0;

  assign w_beat_ack   = ((r_state == StWr) & wr_valid & wr_ready) |
                        ((r_state == StRd) & rd_valid & rd_ready);
  assign w_flush_beat = (r_state == StFlush) & (r_we ? wr_ready : rd_valid);
  assign w_cnt_dec    = (r_cnt != 5'd0) ? r_cnt - 5'd1 : 5'd0;

  always_comb begin
    wb_ack_o          = '0;
    wb_ack_o[r_grant] = w_beat_ack;
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_ptr   <= PW'(NR_OF_PORTS - 1);
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any) begin
            r_grant <= w_win;
            r_ptr   <= w_win;
            r_we    <= w_win_we;
            r_adr   <= w_win_adr;
            r_len   <= f_len(w_win_cti, w_win_bte);
            r_state <= StCmd;
          end
        end
        StCmd: begin
          if (cmd_ready) begin
            r_cnt   <= r_len;
            r_state <= r_we ? StWr : StRd;
          end
        end
        StWr, StRd: begin
          if (w_beat_ack) begin
            r_cnt <= w_cnt_dec;
            if (r_cnt == 5'd1) begin
              // Linear bursts continue as single-beat commands on the same grant.
              if (w_linear) begin
                r_adr   <= r_adr + ADR_WIDTH'(1);
                r_len   <= 5'd1;
                r_state <= StCmd;
              end else begin
                r_state <= StIdle;
              end
            end
          end else if (!w_cyc_g) begin
            r_state <= StFlush;
          end
        end
        StFlush: begin
          if (r_cnt == 5'd0) begin
            r_state <= StIdle;
          end else if (w_flush_beat) begin
            r_cnt <= w_cnt_dec;
            if (r_cnt == 5'd1) r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_versatile_mem_ctrl_wb_rr.sv
// Bench for versatile_mem_ctrl_wb_rr: directed and randomized bursts against a
// transaction-level model of arbitration, command issue, beat counting and flush.
module tb_versatile_mem_ctrl_wb_rr;
  localparam int NR = 4;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = 4;

  logic             clk, rst;
  logic [NR*AW-1:0] adr_v;
  logic [NR*DW-1:0] dat_v;
  logic [NR*SW-1:0] sel_v;
  logic [NR*3-1:0]  cti_v;
  logic [NR*2-1:0]  bte_v;
  logic [0:NR-1]    we, cyc, stb, ack;
  logic [DW-1:0]    dat_o, wr_dat, rd_dat;
  logic             cmd_valid, cmd_ready, cmd_we, wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AW-1:0]    cmd_adr;
  logic [4:0]       cmd_len;
  logic [SW-1:0]    wr_sel;

  int n_pass = 0, n_total = 0, n_fail = 0;
  int ref_ptr = NR - 1;

  versatile_mem_ctrl_wb_rr #(.NR_OF_PORTS(NR), .ADR_WIDTH(AW), .DAT_WIDTH(DW)) u_dut (
    .wb_clk(clk), .wb_rst(rst), .wb_adr_i_v(adr_v), .wb_dat_i_v(dat_v), .wb_sel_i_v(sel_v),
    .wb_cti_i_v(cti_v), .wb_bte_i_v(bte_v), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_dat_o(dat_o), .wb_ack_o(ack), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_len(cmd_len), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_dat(wr_dat), .wr_sel(wr_sel), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_dat(rd_dat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Spec table: only CTI=010 with a wrap BTE yields a multi-beat command.
  function automatic int ref_len(input logic [2:0] ct, input logic [1:0] bt);
    if (ct != 3'b010) return 1;
    if (bt == 2'd1) return 4;
    if (bt == 2'd2) return 8;
    if (bt == 2'd3) return 16;
    return 1;
  endfunction

  function automatic int ref_winner(input logic [0:NR-1] req);
    for (int i = 1; i <= NR; i++) begin
      int q = (ref_ptr + i) % NR;
      if (req[q]) return q;
    end
    return -1;
  endfunction

  task automatic set_port(input int p, input logic c, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s,
                          input logic [2:0] ct, input logic [1:0] bt);
    cyc[p] = c;
    stb[p] = c;
    we[p]  = w;
    adr_v[(NR-1-p)*AW +: AW] = a;
    dat_v[(NR-1-p)*DW +: DW] = d;
    sel_v[(NR-1-p)*SW +: SW] = s;
    cti_v[(NR-1-p)*3 +: 3]   = ct;
    bte_v[(NR-1-p)*2 +: 2]   = bt;
  endtask

  task automatic check_quiet(input string tag);
    @(negedge clk);
    cmd_ready = 1'b0; wr_ready = 1'b1; rd_valid = 1'b1; rd_dat = $urandom;
    #1;
    chk({tag, ":idle_cmd_valid"}, 64'(cmd_valid), 64'd0);
    chk({tag, ":idle_wr_valid"}, 64'(wr_valid), 64'd0);
    chk({tag, ":idle_rd_ready"}, 64'(rd_ready), 64'd0);
    chk({tag, ":idle_ack"}, 64'(ack), 64'd0);
    @(posedge clk); #1;
    wr_ready = 1'b0; rd_valid = 1'b0;
  endtask

  task automatic wait_cmd(input string tag);
    bit seen = 0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk); #1;
      if (cmd_valid) begin
        seen = 1;
        break;
      end
    end
    chk({tag, ":cmd_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic accept_cmd();
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
  endtask

  task automatic read_beat(input int p, input string tag);
    logic [0:NR-1] e;
    logic [DW-1:0] d;
    @(negedge clk);
    d = $urandom; rd_valid = 1'b1; rd_dat = d;
    #1;
    e = '0; e[p] = 1'b1;
    chk({tag, ":rd_ack"}, 64'(ack), 64'(e));
    chk({tag, ":rd_dat"}, 64'(dat_o), 64'(d));
    @(posedge clk); #1;
    rd_valid = 1'b0;
  endtask

  // One Wishbone burst on a single port, with the bench acting as master and controller.
  task automatic burst(input int p, input logic w, input logic [AW-1:0] a0, input logic [2:0] ct,
                       input logic [1:0] bt, input int nbeats, input int abort_after,
                       input string tag);
    int len, ncmds, cmds_done, pend, acks, flushes, exp_flush, quiet;
    bit lin, granted, aborted, done;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [0:NR-1] eack;
    lin = (ct == 3'b010) && (bt == 2'b00);
    len = ref_len(ct, bt);
    ncmds = lin ? nbeats : 1;
    exp_flush = (abort_after > 0) ? len - abort_after : 0;
    d = $urandom; s = SW'($urandom_range(1, 15));
    set_port(p, 1'b1, w, a0, d, s, (lin && nbeats == 1) ? 3'b111 : ct, bt);
    cmds_done = 0; pend = 0; acks = 0; flushes = 0; quiet = 0;
    granted = 0; aborted = 0; done = 0;
    for (int cy = 0; cy < 400 && !done; cy++) begin
      @(negedge clk);
      cmd_ready = ($urandom_range(0, 2) != 0);
      wr_ready  = ($urandom_range(0, 3) != 0);
      rd_valid  = ($urandom_range(0, 3) != 0);
      rd_dat    = $urandom;
      #1;
      eack = '0;
      if (!granted) begin
        chk({tag, ":arb_cycle_cmd_valid"}, 64'(cmd_valid), 64'd0);
        granted = 1;
      end else if (pend == 0) begin
        chk({tag, ":cmd_valid"}, 64'(cmd_valid), 64'd1);
        chk({tag, ":cmd_we"}, 64'(cmd_we), 64'(w));
        chk({tag, ":cmd_adr"}, 64'(cmd_adr), 64'(lin ? a0 + AW'(cmds_done) : a0));
        chk({tag, ":cmd_len"}, 64'(cmd_len), 64'(lin ? 1 : len));
        chk({tag, ":cmd_excl"}, 64'({wr_valid, rd_ready}), 64'd0);
        if (cmd_ready) begin
          cmds_done++;
          pend = lin ? 1 : len;
        end
      end else if (!aborted) begin
        chk({tag, ":data_cmd_valid"}, 64'(cmd_valid), 64'd0);
        if (w) begin
          chk({tag, ":wr_valid"}, 64'(wr_valid), 64'd1);
          chk({tag, ":wr_dat"}, 64'(wr_dat), 64'(d));
          chk({tag, ":wr_sel"}, 64'(wr_sel), 64'(s));
          eack[p] = wr_ready;
        end else begin
          chk({tag, ":rd_ready"}, 64'(rd_ready), 64'd1);
          chk({tag, ":rd_dat"}, 64'(dat_o), 64'(rd_dat));
          eack[p] = rd_valid;
        end
      end else if (quiet == 0) begin
        chk({tag, ":abort_seen_quiet"}, 64'({wr_valid, rd_ready}), 64'd0);
      end else begin
        chk({tag, ":flush_valid"}, 64'(w ? wr_valid : rd_ready), 64'd1);
        if (w) begin
          chk({tag, ":flush_sel"}, 64'(wr_sel), 64'd0);
          chk({tag, ":flush_dat"}, 64'(wr_dat), 64'd0);
        end
        if (w ? wr_ready : rd_valid) begin
          flushes++;
          pend--;
        end
      end
      chk({tag, ":ack"}, 64'(ack), 64'(eack));
      @(posedge clk); #1;
      if (aborted) quiet++;
      if (eack[p]) begin
        acks++;
        pend--;
        d = $urandom; s = SW'($urandom_range(0, 15));
        if (acks == nbeats) begin
          set_port(p, 1'b0, w, a0, d, s, 3'b000, 2'b00);
          done = 1;
        end else if (acks == abort_after) begin
          set_port(p, 1'b0, w, a0, d, s, ct, bt);
          aborted = 1;
        end else begin
          set_port(p, 1'b1, w, a0 + AW'(acks), d, s,
                   (lin && acks == nbeats - 1) ? 3'b111 : ct, bt);
        end
      end
      if (aborted && pend == 0) done = 1;
    end
    cmd_ready = 1'b0; wr_ready = 1'b0; rd_valid = 1'b0;
    chk({tag, ":finished"}, 64'(done), 64'd1);
    chk({tag, ":n_cmds"}, 64'(cmds_done), 64'(ncmds));
    chk({tag, ":n_acks"}, 64'(acks), 64'(abort_after > 0 ? abort_after : nbeats));
    chk({tag, ":n_flush"}, 64'(flushes), 64'(exp_flush));
    ref_ptr = p;
    check_quiet(tag);
  endtask

  initial begin
    logic [0:NR-1] req;
    int win;
    cyc = '0; stb = '0; we = '0;
    adr_v = '0; dat_v = '0; sel_v = '0; cti_v = '0; bte_v = '0;
    cmd_ready = 1'b0; wr_ready = 1'b0; rd_valid = 1'b0; rd_dat = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset:outputs", 64'({cmd_valid, cmd_we, wr_valid, rd_ready, ack, cmd_len}), 64'd0);
    chk("reset:adr_dat", 64'({cmd_adr, dat_o}), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    burst(1, 1'b1, AW'('h100), 3'b000, 2'b00, 1, 0, "t1_single_write");

    // Ports 0,2,3 keep requesting single reads; grants must follow the rotation.
    for (int p = 0; p < NR; p++)
      if (p != 1) set_port(p, 1'b1, 1'b0, AW'('h200 + p), '0, 4'hF, 3'b000, 2'b00);
    req = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      win = ref_winner(req);
      ref_ptr = win;
      wait_cmd("t2_rotate");
      chk("t2_rotate:cmd_adr", 64'(cmd_adr), 64'('h200 + win));
      chk("t2_rotate:cmd_we_len", 64'({cmd_we, cmd_len}), 64'(1));
      accept_cmd();
      read_beat(win, "t2_rotate");
    end
    cyc = '0; stb = '0;
    check_quiet("t2_rotate");

    burst(0, 1'b0, AW'('h13), 3'b010, 2'b10, 8, 0, "t3_wrap8_read");
    burst(2, 1'b1, AW'($urandom), 3'b010, 2'b00, 5, 0, "t4_linear_write");
    burst(1, 1'b1, AW'($urandom), 3'b010, 2'b11, 16, 6, "t5_wrap16_abort");
    burst(3, 1'b0, AW'($urandom), 3'b010, 2'b01, 4, 2, "rd_wrap4_abort");

    for (int it = 0; it < 14; it++) begin
      int p, kind, n, ab;
      logic w;
      logic [2:0] ct;
      logic [1:0] bt;
      p = $urandom_range(0, NR - 1);
      w = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 4);
      ab = 0;
      if (kind == 0) begin
        ct = 3'b000; bt = 2'($urandom_range(0, 3)); n = 1;
      end else if (kind == 4) begin
        ct = 3'b010; bt = 2'b00; n = $urandom_range(2, 5);
      end else begin
        ct = 3'b010; bt = 2'(kind); n = ref_len(ct, bt);
        if ($urandom_range(0, 2) == 0) ab = $urandom_range(1, n - 1);
      end
      burst(p, w, AW'($urandom), ct, bt, n, ab, "random");
    end

    // Reset in the middle of a wrap4 read with three beats outstanding.
    set_port(0, 1'b1, 1'b0, AW'('h40), '0, 4'hF, 3'b010, 2'b01);
    wait_cmd("t6_reset");
    chk("t6_reset:cmd_len", 64'(cmd_len), 64'd4);
    accept_cmd();
    read_beat(0, "t6_reset");
    @(negedge clk);
    rd_valid = 1'b1; rd_dat = 32'hDEAD_BEEF; wr_ready = 1'b1; cmd_ready = 1'b1; rst = 1'b1;
    #1;
    chk("t6_reset:ctl_outputs", 64'({cmd_valid, cmd_we, wr_valid, rd_ready, ack, cmd_len}),
        64'd0);
    chk("t6_reset:adr_dat", 64'({cmd_adr, dat_o}), 64'd0);
    @(negedge clk);
    rd_valid = 1'b0; wr_ready = 1'b0; cmd_ready = 1'b0; rst = 1'b0;
    ref_ptr = NR - 1;
    set_port(0, 1'b1, 1'b0, AW'('h50), '0, 4'hF, 3'b000, 2'b00);
    set_port(3, 1'b1, 1'b0, AW'('h53), '0, 4'hF, 3'b000, 2'b00);
    req = 4'b1001;
    win = ref_winner(req);
    wait_cmd("t6_after_reset");
    chk("t6_after_reset:winner_adr", 64'(cmd_adr), 64'('h50 + win));
    accept_cmd();
    read_beat(win, "t6_after_reset");
    cyc = '0; stb = '0;
    check_quiet("t6_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
